rat: RTL and testbench

//  Register alias table for the rename stage. Per-physical-register state: arch id (map_table),

---
 rtl/rat.sv | 162 ++++++++++++++++
 tb/tb_rat.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rat.sv
// Register alias table: per-physical-register arch id, valid, visible and committed-mapping state,
// free-register offer and source lookups for rename, with commit/release/undo/restore updates.
module rat #(
    parameter int PHY_REG_NUM       = 64,
    parameter int ARCH_REG_NUM      = 32,
    parameter int PHY_REG_ID_WIDTH  = 6,
    parameter int ARCH_REG_ID_WIDTH = 5,
    parameter int RENAME_WIDTH      = 4,
    parameter int COMMIT_WIDTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [PHY_REG_ID_WIDTH-1:0]  rat_rename_new_phy_id [RENAME_WIDTH],
    output logic [RENAME_WIDTH-1:0]      rat_rename_new_phy_id_valid,
    input  logic [PHY_REG_ID_WIDTH-1:0]  rename_rat_phy_id [RENAME_WIDTH],
    input  logic [RENAME_WIDTH-1:0]      rename_rat_phy_id_valid,
    input  logic [ARCH_REG_ID_WIDTH-1:0] rename_rat_arch_id [RENAME_WIDTH],
    input  logic                         rename_rat_map,
    input  logic [ARCH_REG_ID_WIDTH-1:0] rename_rat_read_arch_id [RENAME_WIDTH][3],
    output logic [PHY_REG_ID_WIDTH-1:0]  rat_rename_read_phy_id [RENAME_WIDTH][3],
    output logic [PHY_REG_NUM-1:0]       rat_rename_map_table_valid,
    output logic [PHY_REG_NUM-1:0]       rat_rename_map_table_visible,
    input  logic [PHY_REG_NUM-1:0]       commit_rat_map_table_valid,
    input  logic [PHY_REG_NUM-1:0]       commit_rat_map_table_visible,
    input  logic                         commit_rat_map_table_restore,
    input  logic [PHY_REG_ID_WIDTH-1:0]  commit_rat_release_phy_id [COMMIT_WIDTH],
    input  logic [COMMIT_WIDTH-1:0]      commit_rat_release_phy_id_valid,
    input  logic                         commit_rat_release_map,
    input  logic [PHY_REG_ID_WIDTH-1:0]  commit_rat_commit_phy_id [COMMIT_WIDTH],
    input  logic [COMMIT_WIDTH-1:0]      commit_rat_commit_phy_id_valid,
    input  logic                         commit_rat_commit_map,
    input  logic [PHY_REG_ID_WIDTH-1:0]  commit_rat_restore_new_phy_id,
    input  logic [PHY_REG_ID_WIDTH-1:0]  commit_rat_restore_old_phy_id,
    input  logic                         commit_rat_restore_map
);

    logic [ARCH_REG_ID_WIDTH-1:0] map_table   [PHY_REG_NUM];
    logic [ARCH_REG_ID_WIDTH-1:0] map_table_d [PHY_REG_NUM];
    logic [PHY_REG_NUM-1:0]       map_commit;
    logic [PHY_REG_NUM-1:0]       map_commit_d;
    logic [PHY_REG_NUM-1:0]       valid_q;
    logic [PHY_REG_NUM-1:0]       valid_d;
    logic [PHY_REG_NUM-1:0]       visible_q;
    logic [PHY_REG_NUM-1:0]       visible_d;
    logic [ARCH_REG_ID_WIDTH-1:0] commit_arch;
    int                           free_cnt;

    assign rat_rename_map_table_valid   = valid_q;
    assign rat_rename_map_table_visible = visible_q;

    // Slot k receives the k-th lowest-indexed invalid register.
    always_comb begin
        free_cnt = 0;
        rat_rename_new_phy_id_valid = '0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            rat_rename_new_phy_id[k] = '0;
        end
        for (int p = 0; p < PHY_REG_NUM; p++) begin
            if (!valid_q[p]) begin
                for (int k = 0; k < RENAME_WIDTH; k++) begin
                    if (free_cnt == k) begin
                        rat_rename_new_phy_id[k]       = PHY_REG_ID_WIDTH'(p);
                        rat_rename_new_phy_id_valid[k] = 1'b1;
                    end
                end
                free_cnt = free_cnt + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            for (int j = 0; j < 3; j++) begin
                rat_rename_read_phy_id[i][j] = '0;
                for (int p = 0; p < PHY_REG_NUM; p++) begin
                    if (valid_q[p] && visible_q[p] &&
                        map_table[p] == rename_rat_read_arch_id[i][j]) begin
                        rat_rename_read_phy_id[i][j] = PHY_REG_ID_WIDTH'(p);
                    end
                end
            end
        end
    end

    // Updates are applied in sequence so that later sources override earlier ones per bit.
    always_comb begin
        valid_d      = valid_q;
        visible_d    = visible_q;
        map_commit_d = map_commit;
        map_table_d  = map_table;
        commit_arch  = '0;

        if (rename_rat_map) begin
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                if (rename_rat_phy_id_valid[i]) begin
                    for (int p = 0; p < PHY_REG_NUM; p++) begin
                        if (visible_d[p] && map_table_d[p] == rename_rat_arch_id[i]) begin
                            visible_d[p] = 1'b0;
                        end
                    end
                    valid_d[rename_rat_phy_id[i]]      = 1'b1;
                    visible_d[rename_rat_phy_id[i]]    = 1'b1;
                    map_commit_d[rename_rat_phy_id[i]] = 1'b0;
                    map_table_d[rename_rat_phy_id[i]]  = rename_rat_arch_id[i];
                end
            end
        end

        if (commit_rat_commit_map) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (commit_rat_commit_phy_id_valid[i]) begin
                    commit_arch = map_table_d[commit_rat_commit_phy_id[i]];
                    for (int p = 0; p < PHY_REG_NUM; p++) begin
                        if (valid_d[p] && map_table_d[p] == commit_arch) begin
                            map_commit_d[p] = 1'b0;
                        end
                    end
                    map_commit_d[commit_rat_commit_phy_id[i]] = 1'b1;
                end
            end
        end

        if (commit_rat_release_map) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (commit_rat_release_phy_id_valid[i]) begin
                    valid_d[commit_rat_release_phy_id[i]]      = 1'b0;
                    visible_d[commit_rat_release_phy_id[i]]    = 1'b0;
                    map_commit_d[commit_rat_release_phy_id[i]] = 1'b0;
                end
            end
        end

        if (commit_rat_restore_map) begin
            valid_d[commit_rat_restore_new_phy_id]   = 1'b0;
            visible_d[commit_rat_restore_new_phy_id] = 1'b0;
            valid_d[commit_rat_restore_old_phy_id]   = 1'b1;
            visible_d[commit_rat_restore_old_phy_id] = 1'b1;
        end

        if (commit_rat_map_table_restore) begin
            valid_d   = commit_rat_map_table_valid;
            visible_d = commit_rat_map_table_visible;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < PHY_REG_NUM; p++) begin
                valid_q[p]    <= (p >= 1 && p < ARCH_REG_NUM);
                visible_q[p]  <= (p >= 1 && p < ARCH_REG_NUM);
                map_commit[p] <= (p >= 1 && p < ARCH_REG_NUM);
                map_table[p]  <= (p >= 1 && p < ARCH_REG_NUM) ? ARCH_REG_ID_WIDTH'(p) : '0;
            end
        end else begin
            valid_q    <= valid_d;
            visible_q  <= visible_d;
            map_commit <= map_commit_d;
            map_table  <= map_table_d;
        end
    end

endmodule

// File: tb/tb_rat.sv
// Bench for rat: directed boundary steps, then a random rename/commit/undo flow checked against
// a per-architectural-register mapping model.
module tb_rat;
    localparam int PN = 64, AN = 32, PW = 6, AW = 5, RW = 4, CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [PW-1:0] new_id [RW];
    logic [RW-1:0] new_id_valid;
    logic [PW-1:0] ren_phy [RW];
    logic [RW-1:0] ren_phy_valid;
    logic [AW-1:0] ren_arch [RW];
    logic          ren_map;
    logic [AW-1:0] rd_arch [RW][3];
    logic [PW-1:0] rd_phy [RW][3];
    logic [PN-1:0] tbl_valid, tbl_visible, snap_valid, snap_visible;
    logic          tbl_restore;
    logic [PW-1:0] rel_phy [CW];
    logic [CW-1:0] rel_valid;
    logic          rel_map;
    logic [PW-1:0] com_phy [CW];
    logic [CW-1:0] com_valid;
    logic          com_map_s;
    logic [PW-1:0] rst_new, rst_old;
    logic          rst_map;

    rat dut (
        .clk(clk), .rst(rst),
        .rat_rename_new_phy_id(new_id), .rat_rename_new_phy_id_valid(new_id_valid),
        .rename_rat_phy_id(ren_phy), .rename_rat_phy_id_valid(ren_phy_valid),
        .rename_rat_arch_id(ren_arch), .rename_rat_map(ren_map),
        .rename_rat_read_arch_id(rd_arch), .rat_rename_read_phy_id(rd_phy),
        .rat_rename_map_table_valid(tbl_valid), .rat_rename_map_table_visible(tbl_visible),
        .commit_rat_map_table_valid(snap_valid), .commit_rat_map_table_visible(snap_visible),
        .commit_rat_map_table_restore(tbl_restore),
        .commit_rat_release_phy_id(rel_phy), .commit_rat_release_phy_id_valid(rel_valid),
        .commit_rat_release_map(rel_map),
        .commit_rat_commit_phy_id(com_phy), .commit_rat_commit_phy_id_valid(com_valid),
        .commit_rat_commit_map(com_map_s),
        .commit_rat_restore_new_phy_id(rst_new), .commit_rat_restore_old_phy_id(rst_old),
        .commit_rat_restore_map(rst_map)
    );

    // Model: speculative and committed arch->phys maps, allocation flags, in-flight renames.
    typedef struct { int arch; int newp; int oldp; } inf_t;
    int   spec_map [AN];
    int   cmt_map  [AN];
    bit   alloc    [PN];
    inf_t inflight [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ren_map = 0; ren_phy_valid = '0; tbl_restore = 0; rel_map = 0; rel_valid = '0;
        com_map_s = 0; com_valid = '0; rst_map = 0; rst_new = '0; rst_old = '0;
        snap_valid = '0; snap_visible = '0;
        for (int i = 0; i < RW; i++) begin
            ren_phy[i] = '0; ren_arch[i] = '0;
            for (int j = 0; j < 3; j++) rd_arch[i][j] = '0;
        end
        for (int i = 0; i < CW; i++) begin rel_phy[i] = '0; com_phy[i] = '0; end
    endtask

    task automatic tick();
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        rst = 1; tick(); tick(); rst = 0;
        for (int a = 0; a < AN; a++) begin spec_map[a] = a; cmt_map[a] = a; end
        for (int p = 0; p < PN; p++) alloc[p] = (p >= 1 && p < AN);
        inflight.delete();
    endtask

    function automatic int free_k(int k);
        int n = 0;
        for (int p = 0; p < PN; p++) if (!alloc[p]) begin
            if (n == k) return p;
            n++;
        end
        return -1;
    endfunction

    task automatic check_all(input string tag);
        logic [63:0] ev, evis, ecom;
        int e;
        ev = '0; evis = '0; ecom = '0;
        for (int p = 0; p < PN; p++) ev[p] = alloc[p];
        for (int a = 1; a < AN; a++) begin evis[spec_map[a]] = 1'b1; ecom[cmt_map[a]] = 1'b1; end
        chk({tag, "_valid"}, tbl_valid, ev);
        chk({tag, "_visible"}, tbl_visible, evis);
        chk({tag, "_commit"}, dut.map_commit, ecom);
        for (int k = 0; k < RW; k++) begin
            e = free_k(k);
            chk($sformatf("%s_freev%0d", tag, k), 64'(new_id_valid[k]), 64'(e >= 0));
            if (e >= 0) chk($sformatf("%s_free%0d", tag, k), 64'(new_id[k]), 64'(e));
        end
        for (int i = 0; i < RW; i++)
            for (int j = 0; j < 3; j++) rd_arch[i][j] = AW'($urandom_range(0, AN - 1));
        #1;
        for (int i = 0; i < RW; i++)
            for (int j = 0; j < 3; j++)
                chk($sformatf("%s_rd%0d_%0d_a%0d", tag, i, j, rd_arch[i][j]), 64'(rd_phy[i][j]),
                    (rd_arch[i][j] == 0) ? 64'd0 : 64'(spec_map[rd_arch[i][j]]));
    endtask

    task automatic do_rename(input logic [RW-1:0] mask, input int arch [RW]);
        int ph [RW];
        for (int i = 0; i < RW; i++) ph[i] = free_k(i);
        ren_map = 1;
        for (int i = 0; i < RW; i++) if (mask[i]) begin
            ren_phy_valid[i] = 1; ren_phy[i] = PW'(ph[i]); ren_arch[i] = AW'(arch[i]);
            inflight.push_back('{arch: arch[i], newp: ph[i], oldp: spec_map[arch[i]]});
            spec_map[arch[i]] = ph[i];
            alloc[ph[i]] = 1;
        end
        tick();
    endtask

    task automatic do_commit(input int n);
        inf_t e;
        com_map_s = 1; rel_map = 1;
        for (int i = 0; i < n; i++) begin
            e = inflight.pop_front();
            com_valid[i] = 1; com_phy[i] = PW'(e.newp);
            rel_valid[i] = 1; rel_phy[i] = PW'(e.oldp);
            cmt_map[e.arch] = e.newp;
            alloc[e.oldp] = 0;
        end
        tick();
    endtask

    task automatic do_undo();
        inf_t e;
        e = inflight.pop_back();
        rst_map = 1; rst_new = PW'(e.newp); rst_old = PW'(e.oldp);
        spec_map[e.arch] = e.oldp;
        alloc[e.newp] = 0;
        tick();
    endtask

    initial begin
        int arch [RW];
        int r, n;
        logic [RW-1:0] m;
        clear_inputs();
        do_reset();
        check_all("reset");

        arch = '{1, 2, 3, 4};
        do_rename(4'b1111, arch);
        chk("ren_vis_lo", 64'(tbl_visible[4:0]), 64'h01);
        chk("ren_vis_new", 64'(tbl_visible[34:32]), 64'h7);
        check_all("ren");

        do_commit(4);
        chk("cmt_new", 64'({dut.map_commit[34:32], dut.map_commit[0]}), 64'hF);
        check_all("cmt");

        tbl_restore = 1; snap_valid = 64'habdc71259acd1587; snap_visible = 64'habdc71259acd1587;
        tick();
        chk("tblrst_valid", tbl_valid, 64'habdc71259acd1587);
        chk("tblrst_visible", tbl_visible, 64'habdc71259acd1587);

        do_reset();
        rel_map = 1; rel_valid = 4'b1111;
        for (int i = 0; i < CW; i++) rel_phy[i] = PW'(i + 1);
        tick();
        chk("rel_valid", tbl_valid, 64'h0000_0000_FFFF_FFE0);
        chk("rel_visible", tbl_visible, 64'h0000_0000_FFFF_FFE0);

        do_reset();
        rst_map = 1; rst_new = 6'd1; rst_old = 6'd0;
        tick();
        chk("undo_valid", 64'(tbl_valid[1:0]), 64'h1);
        chk("undo_visible", 64'(tbl_visible[1:0]), 64'h1);

        do_reset();
        check_all("reset2");
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            if (r < 5 && inflight.size() < 24) begin
                m = RW'($urandom_range(1, 15));
                for (int i = 0; i < RW; i++) arch[i] = $urandom_range(1, AN - 1);
                do_rename(m, arch);
            end else if (r < 8 && inflight.size() > 0) begin
                n = $urandom_range(1, (inflight.size() < CW) ? inflight.size() : CW);
                do_commit(n);
            end else if (inflight.size() > 0) begin
                do_undo();
            end else begin
                tick();
            end
            check_all($sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
